sram_responder: RTL and testbench
=================================

// Module: sram_responder
// PURPOSE
// Clocked responder for the active-low CE/WE/OE + A/DQ RAM bus that the RAM
// manager drives onto RAM (SAP1 or RAM controller as master). It stands in for
// the external RAM: holds a 2^AW x DW array, accepts writes, and returns read
// data after a programmable latency, with READY flagging valid DQ. It also keeps
// access counters and a sticky protocol-error flag for bring-up and debug.
// PARAMETERS
// AW        8   address width; array depth = 2^AW
// DW        8   data width
// READ_LAT  2   clock edges from read-request sample to DQ valid (legal: >=1)
// PORTS
// CLK       in     1   system clock, all state changes on rising edge
// CLR       in     1   asynchronous reset, active-low
// A         in     AW  address from master
// DQ        inout  DW  data bus; sampled on writes, driven only on reads
// CE        in     1   chip enable, active-low
// WE        in     1   write enable, active-low
// OE        in     1   output enable, active-low
// READY     out    1   high while DQ carries valid read data
// WR_COUNT  out    16  completed writes, saturates at 16'hFFFF
// RD_COUNT  out    16  reads that reached the drive state, saturates at 16'hFFFF
// ERR       out    1   sticky: CE=0, WE=0, OE=0 sampled on the same edge
// BEHAVIOUR
// - Bus inputs are synchronous to CLK and are sampled directly, no synchronisers.
// - Decoded request: WR = !CE & !WE; RD = !CE & WE & !OE; otherwise idle.
// - FSM states: IDLE, WRITE, RD_WAIT, RD_DRIVE. Reset state is IDLE.
// - Reset values: READY=0, WR_COUNT=0, RD_COUNT=0, ERR=0, DQ=Z, latches=0.
//   The array is not cleared by CLR.
// - IDLE, on WR: latch A and DQ, go to WRITE.
// - IDLE, on RD: latch A, load wait counter with READ_LAT-1, go to RD_WAIT.
// - WRITE: while WR holds, re-latch A and DQ each edge (last value wins).
//   - On the first edge where WR is false: write mem[A_lat] <= D_lat and
//     increment WR_COUNT, all on that edge.
//   - Then go to IDLE, or go straight to RD_WAIT (latching A) if RD holds on that edge.
// - RD_WAIT: decrement the wait counter each edge; DQ=Z and READY=0.
//   - WR seen: go to WRITE, latching A/DQ.
//   - Neither RD nor WR: go to IDLE, no count.
//   - RD with A != A_lat: re-latch A and reload READ_LAT-1.
//   - RD with counter==0: go to RD_DRIVE and increment RD_COUNT.
//   - Net latency: RD first sampled at edge N gives READY=1 and DQ valid after
//     edge N+READ_LAT.
// - RD_DRIVE: READY=1; the registered read data mem[A_lat] is held.
//   - RD with A == A_lat: stay.
//   - RD with A != A_lat: go to RD_WAIT with a reload (READY drops next cycle).
//   - WR: go to WRITE.
//   - Neither: go to IDLE.
// - DQ drive (combinational): DQ = rdata only when state==RD_DRIVE & !CE & !OE & WE;
//   else Z. The bus is released in the same cycle the master deasserts, never one later.
// - Write wins over read: CE=WE=OE=0 is treated as WR and also sets ERR.
//   ERR clears only on CLR.
// - Counters never wrap; they hold at 16'hFFFF.
// - CLR mid-operation: any pending write is discarded; DQ goes Z and READY goes 0
//   asynchronously. Array contents written before the reset are kept.
// TESTING
// 1 READ_LAT=2: WR A=0x3C DQ=0xA5 for 2 cycles, then WE=1
//   -> mem[0x3C]=0xA5, WR_COUNT=1, DQ never driven.
// 2 RD A=0x3C first sampled at edge N -> DQ=Z through edge N+1; DQ=0xA5 and
//   READY=1 after edge N+2; RD_COUNT=1; OE=1 -> DQ=Z in the same cycle.
// 3 RD A=0x3C, OE=1 after one edge -> back to IDLE; DQ stays Z, RD_COUNT unchanged.
// 4 In RD_DRIVE change A 0x3C->0x3D (mem=0x5A) -> READY=0 next cycle;
//   DQ=0x5A two edges later; RD_COUNT +1.
// 5 CE=WE=OE=0, A=0x10, DQ=0x77, then WE=1 -> ERR=1, mem[0x10]=0x77,
//   DQ never driven by the block.
// 6 CLR=0 while in RD_DRIVE -> DQ=Z and READY=0 immediately, counters=0, ERR=0;
//   after release, RD 0x3C still returns 0xA5.

Source files
------------

// File: rtl/sram_responder.sv
// sram_responder: stands in for an external RAM on an active-low CE/WE/OE + A/DQ bus.
// Holds a 2^AW x DW array, accepts writes, and returns read data after READ_LAT edges.
// It also keeps saturating access counters and a sticky protocol-error flag.
// Ports:
//   CLK       system clock, rising edge
//   CLR       asynchronous reset, active-low
//   A         address from master
//   DQ        bidirectional data; sampled on writes, driven only while a read is presented
//   CE/WE/OE  active-low chip/write/output enables
//   READY     high while DQ carries valid read data
//   WR_COUNT  completed writes, saturating
//   RD_COUNT  reads that reached the drive state, saturating
//   ERR       sticky: CE, WE and OE all low on the same edge
module sram_responder #(
    parameter int unsigned AW       = 8,
    parameter int unsigned DW       = 8,
    parameter int unsigned READ_LAT = 2
) (
    input  logic          CLK,
    input  logic          CLR,
    input  logic [AW-1:0] A,
    inout  wire  [DW-1:0] DQ,
    input  logic          CE,
    input  logic          WE,
    input  logic          OE,
    output logic          READY,
    output logic [15:0]   WR_COUNT,
    output logic [15:0]   RD_COUNT,
    output logic          ERR
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(READ_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_RD_WAIT,
        S_RD_DRIVE
    } state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    a_q, a_d;
    logic [DW-1:0]    d_q, d_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic             ready_q, ready_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic             err_q, err_d;

    logic [DW-1:0]    mem [DEPTH];

    logic wr_c;
    logic rd_c;
    logic a_hit_c;
    logic mem_we_c;
    logic dq_oe_c;

    // Bus decode; write wins when CE, WE and OE are all low.
    assign wr_c    = !CE && !WE;
    assign rd_c    = !CE && WE && !OE;
    assign a_hit_c = (A == a_q);

    // Next-state, latches, counters and array write strobe.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        d_d      = d_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        err_d    = err_q || (!CE && !WE && !OE);
        mem_we_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (wr_c) begin
                    a_d     = A;
                    d_d     = DQ;
                    state_d = S_WRITE;
                end else if (rd_c) begin
                    a_d     = A;
                    cnt_d   = LAT_RELOAD;
                    state_d = S_RD_WAIT;
                end
            end
            S_WRITE: begin
                if (wr_c) begin
                    // Last address/data presented before WR drops wins.
                    a_d = A;
                    d_d = DQ;
                end else begin
                    mem_we_c = 1'b1;
                    wr_cnt_d = (wr_cnt_q == CNT_MAX) ? wr_cnt_q : wr_cnt_q + CNT_W'(1);
                    if (rd_c) begin
                        a_d     = A;
                        cnt_d   = LAT_RELOAD;
                        state_d = S_RD_WAIT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_RD_WAIT: begin
                if (wr_c) begin
                    a_d     = A;
                    d_d     = DQ;
                    state_d = S_WRITE;
                end else if (!rd_c) begin
                    state_d = S_IDLE;
                end else if (!a_hit_c) begin
                    a_d   = A;
                    cnt_d = LAT_RELOAD;
                end else if (cnt_q == '0) begin
                    rdata_d  = mem[a_q];
                    rd_cnt_d = (rd_cnt_q == CNT_MAX) ? rd_cnt_q : rd_cnt_q + CNT_W'(1);
                    state_d  = S_RD_DRIVE;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            S_RD_DRIVE: begin
                if (wr_c) begin
                    a_d     = A;
                    d_d     = DQ;
                    state_d = S_WRITE;
                end else if (!rd_c) begin
                    state_d = S_IDLE;
                end else if (!a_hit_c) begin
                    a_d     = A;
                    cnt_d   = LAT_RELOAD;
                    state_d = S_RD_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_RD_DRIVE);
    end

    // Control state; reset drops READY and discards any write still in flight.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            d_q      <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            ready_q  <= 1'b0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            d_q      <= d_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            ready_q  <= ready_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            err_q    <= err_d;
        end
    end

    // Array contents survive CLR.
    always_ff @(posedge CLK) begin
        if (mem_we_c) begin
            mem[a_q] <= d_q;
        end
    end

    // Drive DQ only while the master still presents a read, so release is same-cycle.
    assign dq_oe_c = (state_q == S_RD_DRIVE) && !CE && !OE && WE;
    assign DQ      = dq_oe_c ? rdata_q : {DW{1'bz}};

    assign READY    = ready_q;
    assign WR_COUNT = wr_cnt_q;
    assign RD_COUNT = rd_cnt_q;
    assign ERR      = err_q;

endmodule

// File: tb/tb_sram_responder.sv
// Testbench for sram_responder: directed bus transactions; expected read responses
// are queued by the stimulus and checked by a monitor on each READY rising edge.
module tb_sram_responder;

    localparam int unsigned AW       = 8;
    localparam int unsigned DW       = 8;
    localparam int unsigned READ_LAT = 2;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  data;
        logic [15:0] rdc;
    } exp_t;

    logic          clk;
    logic          clr;
    logic [AW-1:0] a;
    logic [DW-1:0] dout;
    logic          den;
    logic          ce;
    logic          we;
    logic          oe;
    wire  [DW-1:0] dq;
    logic          ready;
    logic [15:0]   wr_count;
    logic [15:0]   rd_count;
    logic          err;

    int unsigned cyc;
    int unsigned checks;
    int unsigned fails;
    exp_t        sb_q[$];

    assign dq = den ? dout : {DW{1'bz}};

    sram_responder #(
        .AW       (AW),
        .DW       (DW),
        .READ_LAT (READ_LAT)
    ) dut (
        .CLK      (clk),
        .CLR      (clr),
        .A        (a),
        .DQ       (dq),
        .CE       (ce),
        .WE       (we),
        .OE       (oe),
        .READY    (ready),
        .WR_COUNT (wr_count),
        .RD_COUNT (rd_count),
        .ERR      (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // A bus with nobody driving reads as Z (or as all-zero in a two-state simulator).
    function automatic logic released(input logic [DW-1:0] v);
        return $isunknown(v) || (v == '0);
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic bus_idle();
        ce = 1'b1; we = 1'b1; oe = 1'b1; den = 1'b0;
    endtask

    task automatic bus_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        a = addr; dout = data; den = 1'b1; ce = 1'b0; we = 1'b0; oe = 1'b1;
    endtask

    task automatic bus_read(input logic [AW-1:0] addr);
        a = addr; den = 1'b0; ce = 1'b0; we = 1'b1; oe = 1'b0;
    endtask

    // Inputs set now are first sampled at edge cyc+1; READY must rise READ_LAT edges later.
    task automatic expect_read(input logic [7:0] data, input logic [15:0] rdc);
        exp_t e;
        e.cyc  = cyc + 1 + READ_LAT;
        e.data = data;
        e.rdc  = rdc;
        sb_q.push_back(e);
    endtask

    // Monitor: every READY rising edge must match the oldest queued response.
    initial begin
        logic ready_prev;
        exp_t e;
        ready_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (ready && !ready_prev) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_ready: got ready at cycle %0d expected none", cyc);
                end else begin
                    e = sb_q.pop_front();
                    chk("rd_latency_cycle", 32'(cyc), 32'(e.cyc));
                    chk("rd_data", 32'(dq), 32'(e.data));
                    chk("rd_count_at_ready", 32'(rd_count), 32'(e.rdc));
                end
            end
            ready_prev = ready;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        cyc = 0; checks = 0; fails = 0;
        clr = 1'b0; a = '0; dout = '0;
        bus_idle();
        step(2);
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_wr_count", 32'(wr_count), 32'd0);
        chk("reset_rd_count", 32'(rd_count), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_dq_z", 32'(released(dq)), 32'd1);
        clr = 1'b1;
        step(1);

        // 1: two-cycle write, then a second location for the address-change test
        bus_write(8'h3C, 8'hA5);
        step(2);
        bus_idle();
        step(1);
        chk("t1_wr_count", 32'(wr_count), 32'd1);
        chk("t1_ready", 32'(ready), 32'd0);
        chk("t1_dq_z", 32'(released(dq)), 32'd1);
        bus_write(8'h3D, 8'h5A);
        step(1);
        bus_idle();
        step(1);
        chk("t1_wr_count2", 32'(wr_count), 32'd2);

        // 2: read with latency, then same-cycle release on OE
        bus_read(8'h3C);
        expect_read(8'hA5, 16'd1);
        step(1);
        chk("t2_dq_z_edge_n", 32'(released(dq)), 32'd1);
        chk("t2_ready_edge_n", 32'(ready), 32'd0);
        step(1);
        chk("t2_dq_z_edge_n1", 32'(released(dq)), 32'd1);
        step(2);
        chk("t2_dq_held", 32'(dq), 32'hA5);
        oe = 1'b1;
        #1;
        chk("t2_release_same_cycle", 32'(released(dq)), 32'd1);
        bus_idle();
        step(1);
        chk("t2_rd_count", 32'(rd_count), 32'd1);
        chk("t2_ready_off", 32'(ready), 32'd0);

        // 3: read abandoned after one edge
        bus_read(8'h3C);
        step(1);
        bus_idle();
        step(3);
        chk("t3_ready", 32'(ready), 32'd0);
        chk("t3_dq_z", 32'(released(dq)), 32'd1);
        chk("t3_rd_count", 32'(rd_count), 32'd1);

        // 4: address change while driving restarts the latency
        bus_read(8'h3C);
        expect_read(8'hA5, 16'd2);
        step(4);
        a = 8'h3D;
        expect_read(8'h5A, 16'd3);
        step(1);
        chk("t4_ready_drop", 32'(ready), 32'd0);
        step(3);
        bus_idle();
        step(1);
        chk("t4_rd_count", 32'(rd_count), 32'd3);

        // 5: CE=WE=OE=0 acts as a write and flags ERR; WE release turns it into a read
        ce = 1'b0; we = 1'b0; oe = 1'b0; a = 8'h10; dout = 8'h77; den = 1'b1;
        step(1);
        chk("t5_err", 32'(err), 32'd1);
        chk("t5_no_contention", 32'(dq), 32'h77);
        we = 1'b1; den = 1'b0;
        expect_read(8'h77, 16'd4);
        step(1);
        chk("t5_wr_count", 32'(wr_count), 32'd3);
        step(3);
        bus_idle();
        step(1);
        chk("t5_err_sticky", 32'(err), 32'd1);
        chk("t5_rd_count", 32'(rd_count), 32'd4);

        // 6: reset while driving; array contents survive
        bus_read(8'h3C);
        expect_read(8'hA5, 16'd5);
        step(4);
        clr = 1'b0;
        #1;
        chk("t6_ready_async", 32'(ready), 32'd0);
        chk("t6_dq_z_async", 32'(released(dq)), 32'd1);
        chk("t6_wr_count", 32'(wr_count), 32'd0);
        chk("t6_rd_count", 32'(rd_count), 32'd0);
        chk("t6_err", 32'(err), 32'd0);
        bus_idle();
        step(1);
        clr = 1'b1;
        step(1);
        bus_read(8'h3C);
        expect_read(8'hA5, 16'd1);
        step(4);
        bus_idle();
        step(1);
        chk("t6_rd_count_after", 32'(rd_count), 32'd1);
        chk("t6_wr_count_after", 32'(wr_count), 32'd0);

        step(3);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
